// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto the data cache over a req/ack handshake
//   clk, rst                   clock, synchronous active-high reset
//   op_valid, op_is_store      memory op present in MEM, store/load select
//   load_type, store_type      access kind (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr, wdata                byte address, right-justified store data
//   stall, done, rdata_ext     pipeline hold, completion pulse, extended load result
//   misaligned, bus_err        alignment fault (no access issued), ack timeout
//   cache_req/we/addr/wdata/be request to the data cache
//   cache_ack, cache_rdata     cache completion and read word
module mem_access_ctrl #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_is_store,
    input  logic [2:0]  load_type,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        bus_err,
    output logic        cache_req,
    output logic        cache_we,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_wdata,
    output logic [3:0]  cache_be,
    input  logic        cache_ack,
    input  logic [31:0] cache_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t          state;
    logic [TO_W-1:0] cnt;
    logic [2:0]      lt;
    logic [1:0]      lane;
    logic [1:0]      sz;
    logic            active;
    logic            go;
    logic            timeout;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic [31:0]     sh;
    logic [31:0]     ext;
    // access size: 1 = byte, 2 = half, 3 = word, 0 = no access (incl. illegal load types)
    always_comb begin
        sz = op_is_store ? store_type :
             (load_type == 3'd1 || load_type == 3'd4) ? 2'd1 :
             (load_type == 3'd2 || load_type == 3'd5) ? 2'd2 :
             (load_type == 3'd3) ? 2'd3 : 2'd0;
    end
    assign active     = op_valid & (sz != 2'd0);
    assign misaligned = active & ((sz == 2'd2 & addr[0]) | (sz == 2'd3 & |addr[1:0]));
    assign go         = (state == IDLE) & active & ~misaligned;
    assign stall      = go | (state == REQ);
    assign timeout    = (ACK_TIMEOUT != 0) && (cnt == TO_W'(ACK_TIMEOUT - 1));
    always_comb begin
        be = sz == 2'd1 ? 4'b0001 << addr[1:0] :
             sz == 2'd2 ? 4'b0011 << addr[1:0] : 4'b1111;
        wd = sz == 2'd1 ? {4{wdata[7:0]}} :
             sz == 2'd2 ? {2{wdata[15:0]}} : wdata;
    end
    // bring the addressed lane down to bit 0, then extend per the captured load type
    always_comb begin
        sh  = cache_rdata >> {lane, 3'b000};
        ext = lt == 3'd1 ? {{24{sh[7]}}, sh[7:0]} :
              lt == 3'd2 ? {{16{sh[15]}}, sh[15:0]} :
              lt == 3'd3 ? cache_rdata :
              lt == 3'd4 ? {24'd0, sh[7:0]} :
              lt == 3'd5 ? {16'd0, sh[15:0]} : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rdata_ext   <= '0;
            done        <= 1'b0;
            bus_err     <= 1'b0;
            cache_req   <= 1'b0;
            cache_we    <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            cache_be    <= '0;
            lt          <= '0;
            lane        <= '0;
        end else begin
            done    <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state       <= REQ;
                    cnt         <= '0;
                    cache_req   <= 1'b1;
                    cache_we    <= op_is_store;
                    cache_addr  <= {addr[31:2], 2'b00};
                    cache_be    <= op_is_store ? be : 4'b0000;
                    cache_wdata <= op_is_store ? wd : 32'd0;
                    lt          <= op_is_store ? 3'd0 : load_type;
                    lane        <= addr[1:0];
                end
                REQ: if (cache_ack) begin
                    state     <= DONE;
                    cache_req <= 1'b0;
                    done      <= 1'b1;
                    rdata_ext <= ext;
                end else if (timeout) begin
                    state     <= DONE;
                    cache_req <= 1'b0;
                    done      <= 1'b1;
                    bus_err   <= 1'b1;
                    rdata_ext <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for mem_access_ctrl (default timeout plus a short-timeout instance)
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst, rst_to;
    logic        op_valid, op_is_store;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr, wdata;
    logic        cache_ack;
    logic [31:0] cache_rdata;
    logic        stall, done, misaligned, bus_err, cache_req, cache_we;
    logic [31:0] rdata_ext, cache_addr, cache_wdata;
    logic [3:0]  cache_be;
    logic        to_stall, to_done, to_mis, to_berr, to_req, to_we;
    logic [31:0] to_rdata, to_addr, to_wdata;
    logic [3:0]  to_be;
    int          errors = 0;
    int          checks = 0;
    int          stalls, reqs;
    logic        gd;
    logic [31:0] rd;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_is_store(op_is_store),
        .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata_ext(rdata_ext), .misaligned(misaligned),
        .bus_err(bus_err), .cache_req(cache_req), .cache_we(cache_we),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_be(cache_be),
        .cache_ack(cache_ack), .cache_rdata(cache_rdata)
    );

    mem_access_ctrl #(.ACK_TIMEOUT(4), .TO_W(3)) dut_to (
        .clk(clk), .rst(rst | rst_to), .op_valid(op_valid), .op_is_store(op_is_store),
        .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
        .stall(to_stall), .done(to_done), .rdata_ext(to_rdata), .misaligned(to_mis),
        .bus_err(to_berr), .cache_req(to_req), .cache_we(to_we),
        .cache_addr(to_addr), .cache_wdata(to_wdata), .cache_be(to_be),
        .cache_ack(cache_ack), .cache_rdata(cache_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rdat);
        @(negedge clk);
        op_valid = 1; op_is_store = 0; load_type = t; store_type = 0; addr = a;
        @(negedge clk);
        cache_ack = 1; cache_rdata = rdat;
        @(negedge clk);
        cache_ack = 0; op_valid = 0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; rst_to = 1; op_valid = 0; op_is_store = 0; load_type = 0; store_type = 0;
        addr = 0; wdata = 0; cache_ack = 0; cache_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_berr", bus_err, 0);
        chk("rst_req", cache_req, 0);
        chk("rst_we", cache_we, 0);
        chk("rst_addr", cache_addr, 0);
        chk("rst_wdata", cache_wdata, 0);
        chk("rst_be", cache_be, 0);
        chk("rst_rdata", rdata_ext, 0);
        @(negedge clk); rst = 0;

        // LB 0x103, ack in first REQ cycle
        @(negedge clk);
        op_valid = 1; load_type = 1; addr = 32'h103;
        #1;
        chk("lb_stall_idle", stall, 1);
        chk("lb_misal", misaligned, 0);
        chk("lb_req_idle", cache_req, 0);
        @(negedge clk); #1;
        chk("lb_req", cache_req, 1);
        chk("lb_addr", cache_addr, 32'h100);
        chk("lb_be", cache_be, 0);
        chk("lb_we", cache_we, 0);
        cache_ack = 1; cache_rdata = 32'h80FF1234;
        @(negedge clk); cache_ack = 0; #1;
        chk("lb_done", done, 1);
        chk("lb_rdata", rdata_ext, 32'hFFFFFF80);
        chk("lb_stall_done", stall, 0);
        chk("lb_berr", bus_err, 0);
        @(negedge clk); op_valid = 0; #1;
        chk("lb_done_once", done, 0);
        chk("lb_no_reissue", cache_req, 0);

        // LHU 0x202, ack in fifth REQ cycle
        @(negedge clk);
        op_valid = 1; load_type = 5; addr = 32'h202; cache_rdata = 32'h80010000;
        gd = 0; stalls = 0; reqs = 0; rd = 0;
        for (int i = 0; i < 8 && !gd; i++) begin
            cache_ack = (i == 5);
            #1;
            stalls += int'(stall);
            reqs += int'(cache_req);
            if (done) begin gd = 1; rd = rdata_ext; end
            @(negedge clk);
        end
        op_valid = 0; cache_ack = 0;
        chk("lhu_done_seen", gd, 1);
        chk("lhu_stall_cycles", stalls, 6);
        chk("lhu_req_cycles", reqs, 5);
        chk("lhu_rdata", rd, 32'h00008001);

        // LH signed half from upper lane
        issue(3'd2, 32'h006, 32'h80010000);
        chk("lh_done", done, 1);
        chk("lh_rdata", rdata_ext, 32'hFFFF8001);

        // SH 0x302
        @(negedge clk);
        op_valid = 1; op_is_store = 1; store_type = 2; load_type = 0; addr = 32'h302; wdata = 32'h0000ABCD;
        #1;
        chk("sh_stall", stall, 1);
        @(negedge clk); #1;
        chk("sh_req", cache_req, 1);
        chk("sh_we", cache_we, 1);
        chk("sh_be", cache_be, 4'b1100);
        chk("sh_wdata", cache_wdata, 32'hABCDABCD);
        chk("sh_addr", cache_addr, 32'h300);
        cache_ack = 1;
        @(negedge clk); cache_ack = 0; op_valid = 0; #1;
        chk("sh_done", done, 1);
        chk("sh_rdata", rdata_ext, 0);

        // SB 0x001
        @(negedge clk);
        op_valid = 1; store_type = 1; addr = 32'h001; wdata = 32'h12345678;
        @(negedge clk); #1;
        chk("sb_be", cache_be, 4'b0010);
        chk("sb_wdata", cache_wdata, 32'h78787878);
        cache_ack = 1;
        @(negedge clk); cache_ack = 0; op_valid = 0; #1;
        chk("sb_done", done, 1);

        // alignment corners, op dropped before the next edge where it would issue
        @(negedge clk);
        op_valid = 1; store_type = 2; addr = 32'h301; #1;
        chk("sh_mis", misaligned, 1);
        chk("sh_mis_stall", stall, 0);
        store_type = 1; addr = 32'h303; #1;
        chk("sb_never_mis", misaligned, 0);
        op_valid = 0; op_is_store = 0; store_type = 0;
        @(negedge clk);
        op_valid = 1; load_type = 6; addr = 32'h401; #1;
        chk("lt6_mis", misaligned, 0);
        chk("lt6_stall", stall, 0);
        op_valid = 0;

        // LW 0x401 misaligned
        @(negedge clk);
        op_valid = 1; load_type = 3; addr = 32'h401; #1;
        chk("lw_mis", misaligned, 1);
        chk("lw_mis_stall", stall, 0);
        @(negedge clk); #1;
        chk("lw_mis_noreq", cache_req, 0);
        op_valid = 0; #1;
        chk("mis_clear", misaligned, 0);

        // short-timeout instance: good LW, then timeout and stray ack
        @(negedge clk); rst_to = 0;
        issue(3'd3, 32'h500, 32'hDEADBEEF);
        chk("lw_rdata", rdata_ext, 32'hDEADBEEF);
        chk("to_lw_done", to_done, 1);
        chk("to_lw_rdata", to_rdata, 32'hDEADBEEF);
        chk("to_lw_berr", to_berr, 0);
        @(negedge clk);
        op_valid = 1; load_type = 3; addr = 32'h504; gd = 0; reqs = 0;
        for (int i = 0; i < 10 && !gd; i++) begin
            #1;
            reqs += int'(to_req);
            if (to_done) begin
                gd = 1;
                chk("to_berr", to_berr, 1);
                chk("to_rdata", to_rdata, 0);
            end
            @(negedge clk);
        end
        chk("to_done_seen", gd, 1);
        chk("to_req_cycles", reqs, 4);
        op_valid = 0; #1;
        chk("to_done_pulse", to_done, 0);
        @(negedge clk); cache_ack = 1; #1;
        chk("to_stray_req", to_req, 0);
        @(negedge clk); cache_ack = 0; #1;
        chk("to_stray_done", to_done, 0);
        chk("to_stray_berr", to_berr, 0);
        @(negedge clk); rst = 1; rst_to = 1;
        @(negedge clk); rst = 0;

        // reset in second REQ cycle
        @(negedge clk);
        op_valid = 1; load_type = 3; addr = 32'h600;
        @(negedge clk); #1;
        chk("rm_req1", cache_req, 1);
        @(negedge clk); rst = 1; op_valid = 0; #1;
        chk("rm_req2", cache_req, 1);
        @(negedge clk); rst = 0; #1;
        chk("rm_req_drop", cache_req, 0);
        chk("rm_stall", stall, 0);
        chk("rm_no_done", done, 0);
        @(negedge clk); cache_ack = 1; #1;
        chk("rm_no_done2", done, 0);
        @(negedge clk); cache_ack = 0; #1;
        chk("rm_late_ack", done, 0);
        chk("rm_late_req", cache_req, 0);
        issue(3'd4, 32'h0, 32'h000000FF);
        chk("lbu_done", done, 1);
        chk("lbu_rdata", rdata_ext, 32'h000000FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
